// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types for the video RAM write port
package vram_pkg;

  localparam int VRAM_ADDR_WIDTH = 17;

  typedef struct packed {
    logic        fill;
    logic [16:0] address;
    logic [7:0]  data;
    logic [16:0] length;
  } vram_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2
  } engine_state_t;

endpackage

// File: rtl/vram_cmd_fifo.sv
// rtl/vram_cmd_fifo.sv - show-ahead command FIFO between host and write engine
module vram_cmd_fifo
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  vram_cmd_t                   pushData,
  input  logic                        pop,
  output vram_cmd_t                   popData,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  vram_cmd_t       storage [FIFO_DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      storage[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign popData = storage[rdPtr];
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - host write/fill port draining a command FIFO into video RAM
module vram_writer
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic                  cmdFill,
  input  logic [ADDR_WIDTH-1:0] cmdAddress,
  input  logic [7:0]            cmdData,
  input  logic [ADDR_WIDTH-1:0] cmdLength,
  input  logic                  blankOnlyMode,
  input  logic                  vBlank,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [7:0]            memData,
  output logic                  memWrite,
  input  logic                  memAck,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  engine_state_t         state;
  engine_state_t         stateNext;
  vram_cmd_t             pushCmd;
  vram_cmd_t             headCmd;
  logic                  push;
  logic                  pop;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  fifoEmptyNext;
  logic                  gateOpen;
  logic                  writeNext;
  logic [CW-1:0]         fifoCount;
  logic [ADDR_WIDTH-1:0] curAddr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [7:0]            curData;

  assign pushCmd = '{fill: cmdFill, address: cmdAddress, data: cmdData, length: cmdLength};
  assign push    = cmdValid && !fifoFull;
  assign cmdReady = !fifoFull;

  vram_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) cmdFifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pushData(pushCmd),
    .pop     (pop),
    .popData (headCmd),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

  // The blanking gate only decides whether a new write may start.
  assign gateOpen = !blankOnlyMode || vBlank;

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    writeNext = memWrite;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          pop       = 1'b1;
          stateNext = LOAD;
        end
      end
      LOAD: begin
        if (remaining == '0) begin
          stateNext = IDLE;
        end else if (gateOpen) begin
          writeNext = 1'b1;
          stateNext = WRITE;
        end
      end
      WRITE: begin
        if (memAck) begin
          if (remaining == ADDR_WIDTH'(1)) begin
            writeNext = 1'b0;
            if (!fifoEmpty) begin
              pop       = 1'b1;
              stateNext = LOAD;
            end else begin
              stateNext = IDLE;
            end
          end else if (!gateOpen) begin
            writeNext = 1'b0;
            stateNext = LOAD;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        writeNext = 1'b0;
      end
    endcase
  end

  assign fifoEmptyNext = ((fifoCount == '0) && !push) ||
                         ((fifoCount == CW'(1)) && pop && !push);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      memWrite  <= 1'b0;
      busy      <= 1'b0;
      curAddr   <= '0;
      curData   <= '0;
      remaining <= '0;
    end else begin
      state    <= stateNext;
      memWrite <= writeNext;
      busy     <= !fifoEmptyNext || (stateNext != IDLE);
      if (pop) begin
        curAddr   <= headCmd.address;
        curData   <= headCmd.data;
        remaining <= headCmd.fill ? headCmd.length : ADDR_WIDTH'(1);
      end else if (state == WRITE && memAck) begin
        curAddr   <= curAddr + ADDR_WIDTH'(1);
        remaining <= remaining - ADDR_WIDTH'(1);
      end
    end
  end

  assign memAddress = curAddr;
  assign memData    = curData;

endmodule

// File: tb/tb_vram_writer.sv
// tb/tb_vram_writer.sv - self-checking bench for vram_writer against a write-list model
module tb_vram_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic        cmdFill = 1'b0;
  logic [16:0] cmdAddress = '0;
  logic [7:0]  cmdData = '0;
  logic [16:0] cmdLength = '0;
  logic        blankOnlyMode = 1'b0;
  logic        vBlank = 1'b1;
  logic [16:0] memAddress;
  logic [7:0]  memData;
  logic        memWrite;
  logic        memAck = 1'b1;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ackMode = 0;
  int holdCnt = 0;
  bit randVB = 0;

  // Model: every accepted command expands into its list of {address, data} RAM writes.
  logic [24:0] expQ[$];

  logic        pv = 0, pa = 0, pGate = 0;
  logic [16:0] pAddr = '0;
  logic [7:0]  pData = '0;

  vram_writer #(.FIFO_DEPTH(8), .ADDR_WIDTH(17)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmdValid     (cmdValid),
    .cmdReady     (cmdReady),
    .cmdFill      (cmdFill),
    .cmdAddress   (cmdAddress),
    .cmdData      (cmdData),
    .cmdLength    (cmdLength),
    .blankOnlyMode(blankOnlyMode),
    .vBlank       (vBlank),
    .memAddress   (memAddress),
    .memData      (memData),
    .memWrite     (memWrite),
    .memAck       (memAck),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RAM side: ack policy and optional random vertical blanking.
  always @(posedge clock) begin
    #1;
    if (!memWrite) holdCnt = 0;
    else if (memAck) holdCnt = 1;
    else holdCnt++;
    case (ackMode)
      0:       memAck = 1'b1;
      1:       memAck = (holdCnt >= 4);
      2:       memAck = 1'($urandom_range(0, 1));
      default: memAck = 1'b0;
    endcase
    if (randVB) vBlank = 1'($urandom_range(0, 1));
  end

  // Write monitor: in-order match, stable hold while stalled, gate open at every write start.
  always @(negedge clock) begin
    if (reset) begin
      pv = 0;
      pa = 0;
    end else begin
      if (pv && !pa) begin
        check("holdWrite", memWrite, 1);
        check("holdAddr", memAddress, pAddr);
        check("holdData", memData, pData);
      end
      if (memWrite && (!pv || pa)) check("gateAtStart", pGate, 1);
      if (memWrite && memAck) begin
        if (expQ.size() == 0) begin
          check("spareWrite", expQ.size(), 1);
        end else begin
          logic [24:0] e;
          e = expQ.pop_front();
          check("writeAddr", memAddress, e[24:8]);
          check("writeData", memData, e[7:0]);
        end
      end
      pv = memWrite;
      pa = memAck;
      pAddr = memAddress;
      pData = memData;
      pGate = !blankOnlyMode || vBlank;
    end
  end

  task automatic sendCmd(input logic fill, input logic [16:0] a, input logic [7:0] d,
                         input logic [16:0] len);
    int g = 0;
    cmdValid = 1'b1;
    cmdFill = fill;
    cmdAddress = a;
    cmdData = d;
    cmdLength = len;
    @(negedge clock);
    while (!cmdReady && g < 3000) begin
      @(negedge clock);
      g++;
    end
    check("sendTimeout", g < 3000, 1);
    if (fill) begin
      for (int i = 0; i < int'(len); i++) begin
        logic [16:0] t;
        t = a + 17'(i);
        expQ.push_back({t, d});
      end
    end else begin
      expQ.push_back({a, d});
    end
    @(posedge clock);
    #1;
    cmdValid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((expQ.size() != 0 || busy) && g < 5000) begin
      @(negedge clock);
      g++;
    end
    check("drainTimeout", g < 5000, 1);
    check("idleWrite", memWrite, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int hi;
    int g;

    #1;
    check("rstWrite", memWrite, 0);
    check("rstAddr", memAddress, 0);
    check("rstData", memData, 0);
    check("rstBusy", busy, 0);
    check("rstReady", cmdReady, 1);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    cycles(2);

    // Single write: latency of two edges, exactly one write cycle, then busy drops.
    sendCmd(1'b0, 17'h00A05, 8'h3C, 17'd0);
    @(negedge clock);
    check("lat1Write", memWrite, 0);
    check("lat1Busy", busy, 1);
    @(negedge clock);
    check("lat2Write", memWrite, 0);
    @(negedge clock);
    check("lat3Write", memWrite, 1);
    check("lat3Addr", memAddress, 17'h00A05);
    check("lat3Data", memData, 8'h3C);
    @(negedge clock);
    check("lat4Write", memWrite, 0);
    check("lat4Busy", busy, 0);
    drain();

    // Fill across the top of the address space: four back-to-back writes.
    sendCmd(1'b1, 17'h1FFFE, 8'hFF, 17'd4);
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("wrapStream", memWrite, 1);
    end
    @(negedge clock);
    check("wrapEnd", memWrite, 0);
    drain();

    // Ack after three stalled cycles: 3 writes x 4 cycles of continuous memWrite.
    ackMode = 1;
    sendCmd(1'b1, 17'h0FFF0, 8'h5A, 17'd3);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (memWrite) hi++;
    end
    check("slowHighCycles", hi, 12);
    check("slowLeft", expQ.size(), 0);
    drain();

    // Nine singles into a stalled RAM: 8 queued plus 1 in the engine fills the FIFO.
    ackMode = 3;
    cycles(1);
    for (int i = 0; i < 9; i++) sendCmd(1'b0, 17'(32'h100 + 3 * i), 8'(i + 1), 17'd0);
    @(negedge clock);
    check("fullReady", cmdReady, 0);
    check("fullBusy", busy, 1);
    cycles(3);
    ackMode = 0;
    drain();
    check("fullReadyAfter", cmdReady, 1);

    // Blank-only mode holds off writes until vBlank; vBlank falling mid-fill only stalls the next write.
    blankOnlyMode = 1'b1;
    vBlank = 1'b0;
    sendCmd(1'b0, 17'h00777, 8'h11, 17'd0);
    cycles(10);
    check("blankHeldWrite", memWrite, 0);
    check("blankHeldQ", expQ.size(), 1);
    vBlank = 1'b1;
    drain();
    ackMode = 1;
    sendCmd(1'b1, 17'h02000, 8'h22, 17'd3);
    g = 0;
    while (!memWrite && g < 50) begin @(negedge clock); g++; end
    check("blankStartTimeout", g < 50, 1);
    @(posedge clock); #1;
    vBlank = 1'b0;
    g = 0;
    while (expQ.size() != 2 && g < 50) begin @(negedge clock); g++; end
    check("blankFirstTimeout", g < 50, 1);
    cycles(8);
    check("blankWaitQ", expQ.size(), 2);
    check("blankWaitWrite", memWrite, 0);
    vBlank = 1'b1;
    drain();
    blankOnlyMode = 1'b0;
    ackMode = 0;

    // Zero-length fill is a no-op; the following single write still lands.
    sendCmd(1'b1, 17'h05555, 8'h99, 17'd0);
    sendCmd(1'b0, 17'h00010, 8'h44, 17'd0);
    drain();

    // Randomized commands, random ack timing and random blanking.
    ackMode = 2;
    randVB = 1;
    for (int n = 0; n < 40; n++) begin
      logic [16:0] a;
      a = ($urandom_range(0, 3) == 0) ? 17'(32'h1FFFF - $urandom_range(0, 4)) : 17'($urandom);
      blankOnlyMode = 1'($urandom_range(0, 1));
      sendCmd(1'($urandom_range(0, 1)), a, 8'($urandom), 17'($urandom_range(0, 6)));
      if (n % 10 == 9) drain();
    end
    randVB = 0;
    vBlank = 1'b1;
    drain();
    blankOnlyMode = 1'b0;

    // Reset during a long fill drops the write at once and flushes everything.
    ackMode = 0;
    sendCmd(1'b1, 17'h00100, 8'h66, 17'd20);
    sendCmd(1'b0, 17'h00300, 8'h67, 17'd0);
    cycles(4);
    #2;
    reset = 1'b1;
    #1;
    check("midRstWrite", memWrite, 0);
    check("midRstBusy", busy, 0);
    check("midRstReady", cmdReady, 1);
    check("midRstAddr", memAddress, 0);
    expQ.delete();
    cycles(2);
    reset = 1'b0;
    cycles(10);
    check("postRstBusy", busy, 0);
    check("postRstWrite", memWrite, 0);
    check("postRstQ", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL globalTimeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
